sw_access_arb: RTL and testbench
================================

// Module: sw_access_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one sw_ctrl field instance between SW_CNT software requesters.
//  Each requester holds a req/ack handshake; the arbiter grants one requester at a time and drives
//  that requester's one-hot sw_wr/sw_rd strobe and data slice into sw_ctrl for exactly one cycle.
//  It samples field_value as read data and returns a single-cycle ack to the requester.
//  Sits between the bus-side register decoder and the field's sw_ctrl/field storage.
// PARAMETERS
//  F_WIDTH  4  field width in bits; matches sw_ctrl F_WIDTH
//  SW_CNT   2  number of requesters (>=1); matches sw_ctrl SW_CNT
// PORTS
//  clk          in   1               clock
//  rst_n        in   1               synchronous reset, active low
//  req          in   SW_CNT          per-requester access request; held high until ack
//  req_wr       in   SW_CNT          1 = write, 0 = read; valid while req is high
//  req_wdata    in   F_WIDTH*SW_CNT  per-requester write data; slice i = [i*F_WIDTH +: F_WIDTH]
//  req_lock     in   SW_CNT          hold grant across accesses (SW_ARB_LOCK_EN only)
//  req_ack      out  SW_CNT          one-cycle completion pulse, one-hot
//  req_rdata    out  F_WIDTH         read data, valid in the req_ack cycle
//  field_value  in   F_WIDTH         current field value
//  sw_wr        out  SW_CNT          one-hot write strobe to sw_ctrl
//  sw_rd        out  SW_CNT          one-hot read strobe to sw_ctrl
//  sw_wr_data   out  F_WIDTH*SW_CNT  write data to sw_ctrl; granted slice only, other slices 0
//  busy         out  1               high in ISSUE and RESP
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr_ptr = SW_CNT-1, so requester 0 has highest priority first.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE. All outputs are registered.
//  - IDLE: if |req, select the first requester set in req, scanning from rr_ptr+1 mod SW_CNT upward.
//    Register grant index g and register req_wr[g] and req_wdata slice g. Next state: ISSUE.
//  - ISSUE (exactly 1 cycle): assert sw_wr[g] if write, else sw_rd[g]; drive sw_wr_data slice g.
//    Capture field_value into req_rdata at the end of this cycle. This gives the pre-side-effect value,
//    e.g. an RCLR field returns its old value. Set rr_ptr = g. Next state: RESP.
//  - RESP (1 cycle): req_ack[g] = 1; req_rdata holds the captured value (write: 0). Strobes are 0.
//    Next state: IDLE.
//  - Latency: req high at edge t -> strobe in cycle t+1 -> ack in cycle t+2. Throughput: 1 access per 3 cycles.
//  - Once latched, grant, type and data are frozen. req deasserting mid-access does not abort it;
//    ack still pulses.
//  - A requester must drop req in the ack cycle or it is treated as a new request, after others under round-robin.
//  - Simultaneous req from all requesters: grants rotate strictly, with no requester granted twice before
//    any other pending requester.
//  - req_rdata holds its value until the next RESP. It is cleared only by reset.
//  - Reset mid-operation: the FSM returns to IDLE at the next edge, and no strobe or ack is emitted
//    after reset asserts.
//  - At most one bit across sw_wr|sw_rd is ever set; req_ack is zero outside RESP.
// CONFIGURATION
//  SW_ARB_LOCK_EN defined:
//    - In RESP, if req_lock[g] && req[g] at that edge, the next IDLE cycle re-grants g regardless of rr_ptr.
//      This gives atomic read-modify-write.
//    - The lock releases when req_lock[g] is 0 in a RESP cycle.
//  SW_ARB_LOCK_EN undefined:
//    - The req_lock port is absent and arbitration is pure round-robin.
// TESTING
//  1. Reset: drive rst_n=0 for 3 cycles with req=2'b11 -> sw_wr, sw_rd, req_ack and busy all 0; rdata=0.
//  2. Single read: field_value=4'hA, req[0]=1, req_wr=0 -> sw_rd=2'b01 in t+1; req_ack=2'b01 and
//     req_rdata=4'hA in t+2.
//  3. Contention: req=2'b11 held continuously, both writes with data 4'h3/4'hC.
//     -> grant order 0,1,0,1; sw_wr_data=8'h03 then 8'hC0; acks alternate.
//  4. Abort: req[1] drops in the ISSUE cycle -> the write still completes and req_ack[1] still pulses once.
//  5. Reset mid-op: rst_n=0 in the ISSUE cycle -> no req_ack next cycle; after release, requester 0 wins
//     against a simultaneous request from requester 1.
//  6. (SW_ARB_LOCK_EN) req_lock[1]=1 with req=2'b11 -> requester 1 granted twice consecutively;
//     requester 0 granted after the lock drops.

Source files
------------

// File: rtl/sw_access_arb.sv
// ---------------------------------------------------------------------------
// sw_access_arb
// Round-robin arbiter that shares one sw_ctrl field instance between SW_CNT
// software requesters. Each access runs IDLE -> ISSUE -> RESP -> IDLE:
//   IDLE  : pick a requester (round-robin from rr_ptr + 1), latch type/index
//   ISSUE : one-cycle sw_wr/sw_rd strobe plus the granted write-data slice
//   RESP  : one-cycle req_ack with the value sampled at the end of ISSUE
// All outputs are registered. The next-output logic is evaluated in the cycle
// before the outputs are meant to be visible.
//
// Optional feature macro: SW_ARB_LOCK_EN
//   Defined   : adds the req_lock port. A requester that holds req_lock and
//               req in its RESP cycle is re-granted on the next IDLE cycle,
//               which gives it atomic read-modify-write sequences.
//   Undefined : no req_lock port, pure round-robin arbitration.
// ---------------------------------------------------------------------------
module sw_access_arb #(
    parameter int F_WIDTH = 4,
    parameter int SW_CNT  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SW_CNT-1:0]           req,
    input  logic [SW_CNT-1:0]           req_wr,
    input  logic [F_WIDTH*SW_CNT-1:0]   req_wdata,
`ifdef SW_ARB_LOCK_EN
    input  logic [SW_CNT-1:0]           req_lock,
`endif
    output logic [SW_CNT-1:0]           req_ack,
    output logic [F_WIDTH-1:0]          req_rdata,
    input  logic [F_WIDTH-1:0]          field_value,
    output logic [SW_CNT-1:0]           sw_wr,
    output logic [SW_CNT-1:0]           sw_rd,
    output logic [F_WIDTH*SW_CNT-1:0]   sw_wr_data,
    output logic                        busy
);

    // Index width; a single requester still needs a 1-bit index.
    localparam int IDX_W = (SW_CNT > 1) ? $clog2(SW_CNT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // First set bit of r, scanning upward from ptr + 1 (wrapping). The loop
    // runs from the farthest candidate to the nearest so the nearest wins.
    function automatic logic [IDX_W-1:0] rr_select(
        input logic [SW_CNT-1:0] r,
        input logic [IDX_W-1:0]  ptr
    );
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] idx;
        sel = ptr;
        for (int k = SW_CNT; k >= 1; k--) begin
            idx = IDX_W'((int'(ptr) + k) % SW_CNT);
            if (r[idx]) begin
                sel = idx;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [SW_CNT-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [SW_CNT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [IDX_W-1:0]           grant_r;     // granted requester, frozen for the access
    logic                       wr_r;        // latched access type (1 = write)
    logic [IDX_W-1:0]           rr_ptr_r;    // last requester served
    logic [IDX_W-1:0]           rr_pick_s;   // round-robin winner
    logic [IDX_W-1:0]           pick_s;      // winner after lock override
`ifdef SW_ARB_LOCK_EN
    logic                       lock_r;      // grant_r keeps priority on the next IDLE
`endif

    logic [SW_CNT-1:0]          sw_wr_nxt_s;
    logic [SW_CNT-1:0]          sw_rd_nxt_s;
    logic [F_WIDTH*SW_CNT-1:0]  sw_wr_data_nxt_s;
    logic [SW_CNT-1:0]          req_ack_nxt_s;
    logic [F_WIDTH-1:0]         req_rdata_nxt_s;
    logic                       busy_nxt_s;

    // Grant selection: round-robin, optionally overridden by a held lock.
    always_comb begin
        rr_pick_s = rr_select(req, rr_ptr_r);
`ifdef SW_ARB_LOCK_EN
        if (lock_r && req[grant_r]) begin
            pick_s = grant_r;
        end else begin
            pick_s = rr_pick_s;
        end
`else
        pick_s = rr_pick_s;
`endif
    end

    // State register plus the per-access bookkeeping (grant, type, rr pointer).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            wr_r     <= 1'b0;
            rr_ptr_r <= IDX_W'(SW_CNT - 1);
`ifdef SW_ARB_LOCK_EN
            lock_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        grant_r <= pick_s;
                        wr_r    <= req_wr[pick_s];
                    end
`ifdef SW_ARB_LOCK_EN
                    // A lock only carries into the IDLE cycle right after RESP.
                    lock_r <= 1'b0;
`endif
                end
                ST_ISSUE: begin
                    rr_ptr_r <= grant_r;
                end
                ST_RESP: begin
`ifdef SW_ARB_LOCK_EN
                    lock_r <= req_lock[grant_r] & req[grant_r];
`endif
                end
                default: begin
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Next-state logic: fixed three-step sequence once a request is seen.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Next-output logic: values the output registers take at the coming edge.
    always_comb begin
        sw_wr_nxt_s      = '0;
        sw_rd_nxt_s      = '0;
        sw_wr_data_nxt_s = '0;
        req_ack_nxt_s    = '0;
        req_rdata_nxt_s  = req_rdata;
        busy_nxt_s       = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    if (req_wr[pick_s]) begin
                        sw_wr_nxt_s = onehot(pick_s);
                    end else begin
                        sw_rd_nxt_s = onehot(pick_s);
                    end
                    sw_wr_data_nxt_s[int'(pick_s)*F_WIDTH +: F_WIDTH] =
                        req_wdata[int'(pick_s)*F_WIDTH +: F_WIDTH];
                end else begin
                    sw_wr_nxt_s = '0;
                    sw_rd_nxt_s = '0;
                end
            end
            ST_ISSUE: begin
                // Sampled at the end of the strobe cycle: the pre-side-effect
                // value, so a read-to-clear field returns its old contents.
                req_ack_nxt_s = onehot(grant_r);
                if (wr_r) begin
                    req_rdata_nxt_s = '0;
                end else begin
                    req_rdata_nxt_s = field_value;
                end
            end
            ST_RESP: begin
                req_ack_nxt_s = '0;
            end
            default: begin
                req_ack_nxt_s = '0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_wr      <= '0;
            sw_rd      <= '0;
            sw_wr_data <= '0;
            req_ack    <= '0;
            req_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            sw_wr      <= sw_wr_nxt_s;
            sw_rd      <= sw_rd_nxt_s;
            sw_wr_data <= sw_wr_data_nxt_s;
            req_ack    <= req_ack_nxt_s;
            req_rdata  <= req_rdata_nxt_s;
            busy       <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_sw_access_arb.sv
// ---------------------------------------------------------------------------
// tb_sw_access_arb
// Directed bench for sw_access_arb. A transaction-level model tracks which
// access phase is in flight and picks winners by round-robin distance from
// the last served requester; a negedge process compares every output against
// it each cycle. Directed steps add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_sw_access_arb;

    localparam int FW = 4;
    localparam int N  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [FW*N-1:0] req_wdata;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_ack;
    logic [FW-1:0]   req_rdata;
    logic [FW-1:0]   field_value;
    logic [N-1:0]    sw_wr;
    logic [N-1:0]    sw_rd;
    logic [FW*N-1:0] sw_wr_data;
    logic            busy;

    sw_access_arb #(.F_WIDTH(FW), .SW_CNT(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_wr      (req_wr),
        .req_wdata   (req_wdata),
`ifdef SW_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ack     (req_ack),
        .req_rdata   (req_rdata),
        .field_value (field_value),
        .sw_wr       (sw_wr),
        .sw_rd       (sw_rd),
        .sw_wr_data  (sw_wr_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = no access in flight, 1 = strobe cycle, 2 = ack cycle
    int            m_phase = 0;
    int            m_g     = 0;
    bit            m_wr    = 1'b0;
    int            m_last  = N - 1;
    bit            m_lock  = 1'b0;
    int            m_pick;
    logic [FW*N-1:0] m_mask;

    logic [N-1:0]    exp_sw_wr  = '0;
    logic [N-1:0]    exp_sw_rd  = '0;
    logic [FW*N-1:0] exp_wdata  = '0;
    logic [N-1:0]    exp_ack    = '0;
    logic [FW-1:0]   exp_rdata  = '0;
    logic            exp_busy   = 1'b0;

    // Pending requester closest (in rotation order) after the last served one.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - last - 1 + 2 * N) % N;
            if (r[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    always_comb begin
        m_pick = rr_pick(req, m_last);
        if (m_lock && req[m_g]) m_pick = m_g;
        m_mask = {{(FW*N-FW){1'b0}}, {FW{1'b1}}} << (m_pick * FW);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase   <= 0;
            m_last    <= N - 1;
            m_lock    <= 1'b0;
            exp_sw_wr <= '0;
            exp_sw_rd <= '0;
            exp_wdata <= '0;
            exp_ack   <= '0;
            exp_rdata <= '0;
            exp_busy  <= 1'b0;
        end else if (m_phase == 0) begin
            m_lock <= 1'b0;
            if (req != '0) begin
                m_g       <= m_pick;
                m_wr      <= req_wr[m_pick];
                exp_sw_wr <= req_wr[m_pick] ? (2'b01 << m_pick) : 2'b00;
                exp_sw_rd <= req_wr[m_pick] ? 2'b00 : (2'b01 << m_pick);
                exp_wdata <= req_wdata & m_mask;
                exp_busy  <= 1'b1;
                m_phase   <= 1;
            end
        end else if (m_phase == 1) begin
            exp_sw_wr <= '0;
            exp_sw_rd <= '0;
            exp_wdata <= '0;
            exp_ack   <= 2'b01 << m_g;
            exp_rdata <= m_wr ? 4'h0 : field_value;
            m_last    <= m_g;
            m_phase   <= 2;
        end else begin
            exp_ack  <= '0;
            exp_busy <= 1'b0;
            m_phase  <= 0;
`ifdef SW_ARB_LOCK_EN
            m_lock   <= req_lock[m_g] & req[m_g];
`endif
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_sw_wr", 32'(sw_wr), 32'(exp_sw_wr));
            chk("m_sw_rd", 32'(sw_rd), 32'(exp_sw_rd));
            chk("m_sw_wr_data", 32'(sw_wr_data), 32'(exp_wdata));
            chk("m_req_ack", 32'(req_ack), 32'(exp_ack));
            chk("m_req_rdata", 32'(req_rdata), 32'(exp_rdata));
            chk("m_busy", 32'(busy), 32'(exp_busy));
            chk("strobe_onehot", 32'($countones(sw_wr | sw_rd) <= 1), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] oh;
    int order [4];

    initial begin
        rst_n       = 1'b0;
        req         = 2'b11;
        req_wr      = 2'b00;
        req_wdata   = 8'h00;
        req_lock    = 2'b00;
        field_value = 4'h0;

        // 1. reset with requests pending
        step();
        chk_en = 1'b1;
        step();
        step();
        chk("rst_sw_wr", 32'(sw_wr), 32'd0);
        chk("rst_sw_rd", 32'(sw_rd), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'(req_rdata), 32'd0);
        chk("model_rst_rdata", 32'(exp_rdata), 32'd0);
        req   = 2'b00;
        rst_n = 1'b1;
        step();

        // 2. single read from requester 0
        field_value = 4'hA;
        req         = 2'b01;
        req_wr      = 2'b00;
        step();
        chk("rd_strobe", 32'(sw_rd), 32'h1);
        chk("rd_no_wr", 32'(sw_wr), 32'h0);
        chk("rd_busy", 32'(busy), 32'h1);
        step();
        chk("rd_ack", 32'(req_ack), 32'h1);
        chk("rd_data", 32'(req_rdata), 32'hA);
        chk("model_rd_data", 32'(exp_rdata), 32'hA);
        req = 2'b00;
        step();
        chk("rd_ack_gone", 32'(req_ack), 32'h0);
        chk("rd_idle", 32'(busy), 32'h0);

        // 3. contention, both writing, requests held throughout
        rst_n = 1'b0;
        step();
        rst_n       = 1'b1;
        req         = 2'b11;
        req_wr      = 2'b11;
        req_wdata   = 8'hC3;
        field_value = 4'h6;
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            step();
            chk("cont_grant", 32'(sw_wr), 32'(oh));
            chk("cont_data", 32'(sw_wr_data), (k % 2 == 0) ? 32'h03 : 32'hC0);
            step();
            chk("cont_ack", 32'(req_ack), 32'(oh));
            chk("cont_wr_rdata", 32'(req_rdata), 32'h0);
            if (k == 3) req = 2'b00;
            step();
        end
        chk("cont_idle", 32'(busy), 32'h0);

        // 4. requester 1 drops req during its strobe cycle
        req       = 2'b10;
        req_wr    = 2'b10;
        req_wdata = 8'h50;
        step();
        chk("abort_strobe", 32'(sw_wr), 32'h2);
        chk("abort_data", 32'(sw_wr_data), 32'h50);
        req = 2'b00;
        step();
        chk("abort_ack", 32'(req_ack), 32'h2);
        step();
        chk("abort_single_ack", 32'(req_ack), 32'h0);
        step();
        chk("abort_idle", 32'(busy), 32'h0);

        // 5. reset during the strobe cycle
        field_value = 4'h9;
        req         = 2'b01;
        req_wr      = 2'b00;
        step();
        chk("rstmid_strobe", 32'(sw_rd), 32'h1);
        rst_n = 1'b0;
        req   = 2'b00;
        step();
        chk("rstmid_no_ack", 32'(req_ack), 32'h0);
        chk("rstmid_no_strobe", 32'(sw_rd), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        step();
        chk("rstmid_no_ack2", 32'(req_ack), 32'h0);
        rst_n = 1'b1;
        req   = 2'b11;
        step();
        chk("rstmid_winner", 32'(sw_rd), 32'h1);
        step();
        chk("rstmid_ack", 32'(req_ack), 32'h1);
        chk("rstmid_rdata", 32'(req_rdata), 32'h9);
        req = 2'b00;
        step();

`ifdef SW_ARB_LOCK_EN
        // 6. requester 1 locks the field for two consecutive accesses
        rst_n = 1'b0;
        step();
        rst_n       = 1'b1;
        req         = 2'b11;
        req_wr      = 2'b00;
        req_lock    = 2'b10;
        field_value = 4'h3;
        order[0] = 0; order[1] = 1; order[2] = 1; order[3] = 0;
        for (int k = 0; k < 4; k++) begin
            oh = 2'b01 << order[k];
            step();
            chk("lock_grant", 32'(sw_rd), 32'(oh));
            if (k == 2) req_lock = 2'b00;
            step();
            chk("lock_ack", 32'(req_ack), 32'(oh));
            if (k == 3) req = 2'b00;
            step();
        end
`else
        order[0] = 0; order[1] = 0; order[2] = 0; order[3] = 0;
`endif

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
